// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the PC, fetches one 16-bit
//                word per instruction over an imem req/ack handshake, issues
//                it to control, resolves beq/bne branches, and detects the
//                halt opcode and memory-response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int          MAX_WAIT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        alu_zero,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] c_OP_BEQ    = 4'b0101;
  localparam logic [3:0] c_OP_BNE    = 4'b0110;
  // Counter value at which the current miss is the MAX_WAIT-th one
  localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        halted_q, halted_d;
  logic        fetch_err_q, fetch_err_d;

  logic        w_taken;
  logic [15:0] w_pc_plus1;
  logic [15:0] w_branch_tgt;
  logic [15:0] w_next_pc;

  // Branch resolution: beq on zero, bne on non-zero; any other opcode falls through
  always_comb begin
    w_pc_plus1   = pc_q + 16'd1;
    w_branch_tgt = w_pc_plus1 + {{10{instr_q[5]}}, instr_q[5:0]};
    w_taken      = branch & (((instr_q[15:12] == c_OP_BEQ) & alu_zero) |
                             ((instr_q[15:12] == c_OP_BNE) & ~alu_zero));
    w_next_pc    = w_taken ? w_branch_tgt : w_pc_plus1;
  end

  // State and datapath registers; reset aborts any outstanding request at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= 16'h0000;
      wait_cnt_q  <= 8'd0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      wait_cnt_q  <= wait_cnt_d;
      halted_q    <= halted_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state logic: fetch handshake with timeout, issue with stall/halt/branch
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    wait_cnt_d  = wait_cnt_q;
    halted_d    = halted_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          wait_cnt_d = 8'd0;
          state_d    = S_ISSUE;
        end else if (wait_cnt_q == c_WAIT_LAST) begin
          wait_cnt_d  = wait_cnt_q + 8'd1;
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (instr_q[15:12] == HALT_OPCODE) begin
            pc_d     = w_pc_plus1;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = w_next_pc;
            state_d = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[15:12];
  assign instr_valid = (state_q == S_ISSUE);
  assign pc          = pc_q;
  assign pc_plus1    = w_pc_plus1;
  assign halted      = halted_q;
  assign fetch_err   = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        stall;
  logic        branch;
  logic        alu_zero;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        halted;
  logic        fetch_err;

  int total;
  int bad;

  fetch_unit #(
    .RESET_PC   (16'h0000),
    .HALT_OPCODE(4'hF),
    .MAX_WAIT   (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .stall      (stall),
    .branch     (branch),
    .alu_zero   (alu_zero),
    .pc         (pc),
    .pc_plus1   (pc_plus1),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset for two cycles and release it; DUT is then in IDLE
  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; stall = 1'b0;
    branch = 1'b0; alu_zero = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a request, then answer it with one ack cycle
  task automatic fetch_word(input logic [15:0] word);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL fetch_wait: imem_req=%b required 1 within 20 cycles", imem_req);
    end
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; imem_rdata = 16'hDEAD;
  endtask

  // Complete one unstalled ISSUE cycle with the given branch inputs
  task automatic issue(input logic br, input logic z);
    branch = br; alu_zero = z; stall = 1'b0;
    tick();
    branch = 1'b0; alu_zero = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; stall = 1'b0;
    branch = 1'b0; alu_zero = 1'b0;
    tick(); tick();
    total++;
    if ({imem_req, instr_valid, opcode, pc, instr, halted, fetch_err} !== 39'd0) begin
      bad++;
      $display("FAIL reset_state: req=%b valid=%b op=%h pc=%h instr=%h halted=%b err=%b required all 0",
               imem_req, instr_valid, opcode, pc, instr, halted, fetch_err);
    end
    reset = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL first_fetch: req=%b addr=%h required 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_basic();
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    imem_ack = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || opcode !== 4'h1 || pc !== 16'h0000 || instr !== 16'h1234 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL basic_issue: valid=%b op=%h pc=%h instr=%h req=%b required 1/1/0000/1234/0",
               instr_valid, opcode, pc, instr, imem_req);
    end
    issue(1'b0, 1'b0);
    total++;
    if (pc !== 16'h0001 || imem_req !== 1'b1 || pc_plus1 !== 16'h0002 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_advance: pc=%h req=%b pc_plus1=%h valid=%b required 0001/1/0002/0",
               pc, imem_req, pc_plus1, instr_valid);
    end
  endtask

  task automatic test_branches();
    // 0x0001 -> beq +14 taken -> 0x0010
    fetch_word(16'h500E); issue(1'b1, 1'b1);
    total++;
    if (pc !== 16'h0010) begin bad++; $display("FAIL beq_setup: pc=%h required 0010", pc); end
    fetch_word(16'h503E);
    total++;
    if (pc !== 16'h0010 || instr !== 16'h503E || opcode !== 4'h5) begin
      bad++; $display("FAIL beq_issue: pc=%h instr=%h op=%h required 0010/503E/5", pc, instr, opcode);
    end
    issue(1'b1, 1'b1);
    total++;
    if (pc !== 16'h000F) begin bad++; $display("FAIL beq_taken_neg: pc=%h required 000F", pc); end
    fetch_word(16'h1000); issue(1'b0, 1'b0);
    fetch_word(16'h503E); issue(1'b1, 1'b0);
    total++;
    if (pc !== 16'h0011) begin bad++; $display("FAIL beq_not_taken: pc=%h required 0011", pc); end
    // 0x0011 -> beq +14 taken -> 0x0020
    fetch_word(16'h500E); issue(1'b1, 1'b1);
    fetch_word(16'h6005); issue(1'b1, 1'b0);
    total++;
    if (pc !== 16'h0026) begin bad++; $display("FAIL bne_taken: pc=%h required 0026", pc); end
    // 0x0026 -> bne -7 taken -> 0x0020
    fetch_word(16'h6039); issue(1'b1, 1'b0);
    total++;
    if (pc !== 16'h0020) begin bad++; $display("FAIL bne_back: pc=%h required 0020", pc); end
    fetch_word(16'h6005); issue(1'b1, 1'b1);
    total++;
    if (pc !== 16'h0021) begin bad++; $display("FAIL bne_not_taken: pc=%h required 0021", pc); end
    fetch_word(16'h7005); issue(1'b1, 1'b1);
    total++;
    if (pc !== 16'h0022) begin bad++; $display("FAIL branch_other_op: pc=%h required 0022", pc); end
    fetch_word(16'h5005); issue(1'b0, 1'b1);
    total++;
    if (pc !== 16'h0023) begin bad++; $display("FAIL beq_branch_low: pc=%h required 0023", pc); end
  endtask

  task automatic test_stall();
    fetch_word(16'h2ABC);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = 16'h9999;
      tick();
      imem_ack = 1'b0;
      total++;
      if (instr !== 16'h2ABC || pc !== 16'h0023 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: instr=%h pc=%h req=%b valid=%b required 2ABC/0023/0/1",
                 i, instr, pc, imem_req, instr_valid);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (pc !== 16'h0024 || imem_req !== 1'b1 || imem_addr !== 16'h0024) begin
      bad++;
      $display("FAIL stall_release: pc=%h req=%b addr=%h required 0024/1/0024", pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    tick(); tick();
    reset = 1'b1;
    #2;
    total++;
    if (imem_req !== 1'b0 || pc !== 16'h0000 || instr !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_fetch: req=%b pc=%h instr=%h required 0/0000/0000", imem_req, pc, instr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_wrap_halt();
    do_reset();
    fetch_word(16'h503E); issue(1'b1, 1'b1);
    total++;
    if (pc !== 16'hFFFF || pc_plus1 !== 16'h0000) begin
      bad++; $display("FAIL branch_wrap: pc=%h pc_plus1=%h required FFFF/0000", pc, pc_plus1);
    end
    fetch_word(16'h1000); issue(1'b0, 1'b0);
    total++;
    if (pc !== 16'h0000 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL pc_wrap: pc=%h err=%b required 0000/0", pc, fetch_err);
    end
    fetch_word(16'hF000); issue(1'b0, 1'b0);
    total++;
    if (halted !== 1'b1 || pc !== 16'h0001 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL halt_opcode: halted=%b pc=%h req=%b valid=%b err=%b required 1/0001/0/0/0",
               halted, pc, imem_req, instr_valid, fetch_err);
    end
    tick(); tick();
    total++;
    if (halted !== 1'b1 || pc !== 16'h0001 || imem_req !== 1'b0) begin
      bad++; $display("FAIL halt_terminal: halted=%b pc=%h req=%b required 1/0001/0", halted, pc, imem_req);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick();  // now in FETCH
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL timeout_early: req=%b err=%b after 14 misses required 1/0", imem_req, fetch_err);
    end
    tick();
    total++;
    if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
      bad++; $display("FAIL timeout: err=%b halted=%b req=%b required 1/1/0", fetch_err, halted, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 16'h4321;
    tick();
    imem_ack = 1'b0;
    tick();
    total++;
    if (instr !== 16'h0000 || instr_valid !== 1'b0 || imem_req !== 1'b0 || fetch_err !== 1'b1) begin
      bad++;
      $display("FAIL late_ack: instr=%h valid=%b req=%b err=%b required 0000/0/0/1",
               instr, instr_valid, imem_req, fetch_err);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_branches();
    test_stall();
    test_reset_mid_fetch();
    test_wrap_halt();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
